// File: rtl/layer_serializer_if.sv
// Parallel-vector-in / serial-stream-out bundle for layer_serializer.
// The master side presents vectors; the slave side (the serializer) emits the stream.
interface layer_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODES  = 20
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] din [NUM_NODES];
  logic                  i_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  o_last;
  logic                  o_overrun;

  modport master (
    output i_valid, din,
    input  i_ready, o_valid, dout, o_last, o_overrun
  );

  modport slave (
    input  i_valid, din,
    output i_ready, o_valid, dout, o_last, o_overrun
  );
endinterface

// File: rtl/layer_serializer.sv
// Captures a NUM_NODES-wide layer output vector and replays it one element per cycle.
// Optional ReLU on the output path when SERIALIZER_RELU_EN is defined.
module layer_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODES  = 20
) (
  input  logic               clk,
  input  logic               rst,
  layer_serializer_if.slave  bus
);

  localparam int unsigned IDX_WIDTH = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NODES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  idx, idx_nxt;
  logic [DATA_WIDTH-1:0] shadow [NUM_NODES];
  logic [DATA_WIDTH-1:0] elem_nxt;
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic                  last_elem;
  logic                  ready;
  logic                  capture;
  logic                  overrun_hit;

  // Ready in idle, or on the final element so a new vector follows without a gap
  assign last_elem   = (idx == LAST_IDX);
  assign ready       = (state == IDLE) || ((state == STREAM) && last_elem);
  assign capture     = bus.i_valid && ready;
  assign overrun_hit = bus.i_valid && !ready;
  assign bus.i_ready = ready;

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    elem_nxt  = '0;

    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (last_elem) begin
          idx_nxt = '0;
          if (!capture) begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt = idx + IDX_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase

    // A fresh capture always starts at element 0, taken straight from din
    if (capture) begin
      elem_nxt = bus.din[0];
    end else if (state_nxt == STREAM) begin
      elem_nxt = shadow[idx_nxt];
    end
  end

  // Output-path transform; shadow keeps raw values either way
  always_comb begin
    dout_nxt = elem_nxt;
`ifdef SERIALIZER_RELU_EN
    if (elem_nxt[DATA_WIDTH-1]) begin
      dout_nxt = '0;
    end
`endif
  end

  // Control state and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_last    <= 1'b0;
      bus.dout      <= '0;
      bus.o_overrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      bus.o_valid   <= (state_nxt == STREAM);
      bus.o_last    <= (state_nxt == STREAM) && (idx_nxt == LAST_IDX);
      bus.dout      <= dout_nxt;
      bus.o_overrun <= bus.o_overrun | overrun_hit;
    end
  end

  // Shadow buffer holds no reset: contents are meaningless until the first capture
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow <= bus.din;
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: stimulus queues expected stream words,
// a negedge monitor pops and compares every o_valid cycle.
module tb_layer_serializer;

  localparam int unsigned DW = 32;
  localparam int unsigned NN = 20;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb [$];
  logic [DW-1:0] vec [NN];

  layer_serializer_if #(.DATA_WIDTH(DW), .NUM_NODES(NN)) bus ();

  layer_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] v);
`ifdef SERIALIZER_RELU_EN
    if (v[DW-1]) return '0;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present vec for one capture edge and queue its expected stream
  task automatic capture_vec();
    bus.din     = vec;
    bus.i_valid = 1'b1;
    for (int k = 0; k < NN; k++) begin
      sb.push_back('{last: (k == NN - 1), data: relu_model(vec[k])});
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Idle-state snapshot {o_valid,o_last,o_overrun,i_ready,dout}
  function automatic logic [63:0] snap();
    return 64'({bus.o_valid, bus.o_last, bus.o_overrun, bus.i_ready, bus.dout});
  endfunction

  // Monitor: every valid output must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dout=%h last=%b with empty scoreboard at %0t",
                 bus.dout, bus.o_last, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("stream_elem", 64'({bus.o_last, bus.dout}), 64'({e.last, e.data}));
      end
    end
  end

  initial begin
    int vcnt;
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    for (int k = 0; k < NN; k++) bus.din[k] = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_after_reset", snap(), 64'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
    end

    // Single vector 1..20
    for (int k = 0; k < NN; k++) vec[k] = DW'(k + 1);
    capture_vec();
    repeat (NN) @(posedge clk);
    @(negedge clk);
    chk("single_done_valid", 64'(bus.o_valid), 64'd0);
    chk("single_done_ready", 64'(bus.i_ready), 64'd1);
    chk("single_drained", 64'(sb.size()), 64'd0);

    // Back-to-back: second vector captured on the o_last cycle
    repeat (2) @(negedge clk);
    capture_vec();
    repeat (NN - 1) @(posedge clk);
    #1;
    chk("b2b_ready_on_last", 64'({bus.i_ready, bus.o_last}), 64'b11);
    for (int k = 0; k < NN; k++) vec[k] = DW'(100 + k);
    capture_vec();
    vcnt = 0;
    for (int c = 0; c < NN; c++) begin
      @(negedge clk);
      if (bus.o_valid) vcnt++;
    end
    chk("b2b_gapless_count", 64'(vcnt), 64'(NN));
    @(negedge clk);
    chk("b2b_end_valid", 64'(bus.o_valid), 64'd0);
    chk("b2b_no_overrun", 64'(bus.o_overrun), 64'd0);

    // Overrun at element 5: stream unaffected, sticky flag set
    for (int k = 0; k < NN; k++) vec[k] = DW'(k + 1);
    capture_vec();
    repeat (5) @(posedge clk);
    #1;
    chk("ovr_not_ready", 64'(bus.i_ready), 64'd0);
    for (int k = 0; k < NN; k++) bus.din[k] = 32'hDEAD_0000 + DW'(k);
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    chk("ovr_set", 64'(bus.o_overrun), 64'd1);
    wait_drain("ovr_drain");
    repeat (3) @(negedge clk);
    chk("ovr_sticky", 64'({bus.o_overrun, bus.o_valid}), 64'b10);

    // Reset mid-stream at element 10
    for (int k = 0; k < NN; k++) vec[k] = DW'(50 + k);
    capture_vec();
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_async_clear", snap(), 64'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", 64'(bus.o_valid), 64'd0);
    for (int k = 0; k < NN; k++) vec[k] = DW'(200 + k);
    capture_vec();
    wait_drain("midrst_restream_drain");

    // Sign-bit patterns: ReLU zeroes them, otherwise they pass unchanged
    vec[0] = 32'hFFFF_FFFF;
    vec[1] = 32'h0000_0005;
    vec[2] = 32'h8000_0000;
    vec[3] = 32'h7FFF_FFFF;
    for (int k = 4; k < NN; k++) vec[k] = (k % 2 == 0) ? DW'(k) : (32'hF000_0000 | DW'(k));
    repeat (2) @(negedge clk);
    capture_vec();
    @(negedge clk);
`ifdef SERIALIZER_RELU_EN
    chk("relu_first_elem", 64'(bus.dout), 64'h0);
`else
    chk("raw_first_elem", 64'(bus.dout), 64'hFFFF_FFFF);
`endif
    wait_drain("relu_drain");

    repeat (3) @(negedge clk);
    chk("final_idle", 64'({bus.o_valid, bus.i_ready}), 64'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
